// File: rtl/counter_top.sv
// rtl/counter_top.sv - free-running prescaled up-counter with configurable step and terminal value
// Smoke-target counter: a 16-bit prescaler gates count events; each event adds STEP or wraps to 0.
module counter_top #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int MAX_VAL  = 255,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] outCounter
);

  localparam int              W1       = WIDTH + 1;
  localparam logic [W1-1:0]   STEP_W   = W1'(STEP);
  localparam logic [W1-1:0]   MAX_W    = W1'(MAX_VAL);
  localparam logic [15:0]     PRE_LAST = 16'(PRESCALE - 1);

  if (longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1) || MAX_VAL < 0) begin : g_bad_max
    $error("counter_top: MAX_VAL %0d does not fit in WIDTH %0d", MAX_VAL, WIDTH);
  end
  if (STEP < 1 || longint'(STEP) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_step
    $error("counter_top: STEP %0d out of range", STEP);
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_pre
    $error("counter_top: PRESCALE %0d out of range", PRESCALE);
  end

  logic [15:0]      pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [W1-1:0]    sum;
  logic             tick;

  always_comb begin
    pre_d = pre_q + 16'd1;
    tick  = 1'b0;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      tick  = 1'b1;
    end

    // Sum carries one extra bit so a step past the top of the range is seen, not wrapped.
    sum   = {1'b0, cnt_q} + STEP_W;
    cnt_d = cnt_q;
    if (tick) begin
      if ({1'b0, cnt_q} >= MAX_W) begin
        cnt_d = '0;
      end else if (sum > MAX_W) begin
        cnt_d = '0;
      end else begin
        cnt_d = sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign outCounter = cnt_q;

endmodule

// File: tb/tb_counter_top.sv
// tb/tb_counter_top.sv - directed self-checking bench for counter_top
// Instance a uses defaults; instance b uses PRESCALE=4, STEP=3, MAX_VAL=10.
module tb_counter_top;

  logic       clk;
  logic       rst_a;
  logic       rst_b;
  logic [7:0] out_a;
  logic [7:0] out_b;

  int n_cmp;
  int n_fail;

  counter_top u_dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .outCounter (out_a)
  );

  counter_top #(
    .WIDTH    (8),
    .STEP     (3),
    .MAX_VAL  (10),
    .PRESCALE (4)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .outCounter (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    edge_step();
    n_cmp++;
    if (out_a !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_a: got %0d expected 0", out_a);
    end
    n_cmp++;
    if (out_b !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_b: got %0d expected 0", out_b);
    end
  endtask

  task automatic test_first_counts();
    logic [7:0] exp_v [3];
    exp_v[0] = 8'd1;
    exp_v[1] = 8'd2;
    exp_v[2] = 8'd3;
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      n_cmp++;
      if (out_a !== exp_v[i]) begin
        n_fail++;
        $display("FAIL first_count[%0d]: got %0d expected %0d", i, out_a, exp_v[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_v;
    int saw_wrap;
    rst_a = 1'b1;
    edge_step();
    rst_a = 1'b0;
    exp_v = 0;
    saw_wrap = 0;
    for (int i = 1; i <= 300; i++) begin
      edge_step();
      exp_v = (exp_v >= 255) ? 0 : exp_v + 1;
      if (i == 256) saw_wrap = 1;
      n_cmp++;
      if (out_a !== 8'(exp_v)) begin
        n_fail++;
        $display("FAIL wrap_model[%0d]: got %0d expected %0d", i, out_a, exp_v);
      end
    end
    n_cmp++;
    if (saw_wrap != 1 || exp_v != 44) begin
      n_fail++;
      $display("FAIL wrap_end: model end %0d expected 44", exp_v);
    end
  endtask

  task automatic test_mid_reset();
    int found;
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      if (out_a === 8'h7F) found = 1;
      else edge_step();
    end
    n_cmp++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL mid_reset_seek: got %0d expected 127 within 600 cycles", out_a);
    end
    rst_a = 1'b1;
    edge_step();
    n_cmp++;
    if (out_a !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset_zero: got %0d expected 0", out_a);
    end
    rst_a = 1'b0;
    edge_step();
    n_cmp++;
    if (out_a !== 8'd1) begin
      n_fail++;
      $display("FAIL mid_reset_resume: got %0d expected 1", out_a);
    end
  endtask

  task automatic test_prescale_step();
    logic [7:0] seq [7];
    seq[0] = 8'd0; seq[1] = 8'd3; seq[2] = 8'd6; seq[3] = 8'd9;
    seq[4] = 8'd0; seq[5] = 8'd3; seq[6] = 8'd6;
    rst_b = 1'b1;
    edge_step();
    rst_b = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      edge_step();
      n_cmp++;
      if (out_b !== seq[k/4]) begin
        n_fail++;
        $display("FAIL prescale_step[%0d]: got %0d expected %0d", k, out_b, seq[k/4]);
      end
    end
  endtask

  task automatic test_long_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge_step();
      n_cmp++;
      if (out_a !== 8'd0 || out_b !== 8'd0) begin
        n_fail++;
        $display("FAIL long_reset[%0d]: got a=%0d b=%0d expected 0 0", i, out_a, out_b);
      end
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      edge_step();
      n_cmp++;
      if (out_a !== 8'(k)) begin
        n_fail++;
        $display("FAIL long_reset_release_a[%0d]: got %0d expected %0d", k, out_a, k);
      end
      n_cmp++;
      if (out_b !== ((k >= 4) ? 8'd3 : 8'd0)) begin
        n_fail++;
        $display("FAIL long_reset_release_b[%0d]: got %0d expected %0d", k, out_b,
                 (k >= 4) ? 3 : 0);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    @(negedge clk);
    test_reset();
    test_first_counts();
    test_wrap();
    test_mid_reset();
    test_prescale_step();
    test_long_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
